// File: rtl/jtcop_gfxarb_pkg.sv
// Shared types and constants for the graphics ROM arbiter.
// Client indices match the order of the per-client cache slots.
package jtcop_gfxarb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

  localparam int NCL = 4;
  localparam int CAW = 18;
  localparam int DW  = 32;

  localparam logic [1:0] CL_BA0 = 2'd0;
  localparam logic [1:0] CL_BA1 = 2'd1;
  localparam logic [1:0] CL_BA2 = 2'd2;
  localparam logic [1:0] CL_OBJ = 2'd3;

  // Object engine first, then BA2, BA0, BA1.
  function automatic logic [1:0] fixed_pick(input logic [NCL-1:0] pend);
    if (pend[CL_OBJ])      return CL_OBJ;
    else if (pend[CL_BA2]) return CL_BA2;
    else if (pend[CL_BA0]) return CL_BA0;
    else                   return CL_BA1;
  endfunction

endpackage

// File: rtl/jtcop_gfxarb_if.sv
// ROM client ports (BA0..BA2, object) plus the shared memory read port.
// slave = arbiter side, master = video/SDRAM side.
interface jtcop_gfxarb_if #(parameter int MEM_AW = 22);
  logic              b0rom_cs;
  logic [17:0]       b0rom_addr;
  logic [31:0]       b0rom_data;
  logic              b0rom_ok;
  logic              b1rom_cs;
  logic [17:0]       b1rom_addr;
  logic [31:0]       b1rom_data;
  logic              b1rom_ok;
  logic              b2rom_cs;
  logic [17:0]       b2rom_addr;
  logic [31:0]       b2rom_data;
  logic              b2rom_ok;
  logic              orom_cs;
  logic [17:0]       orom_addr;
  logic [31:0]       orom_data;
  logic              orom_ok;
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_rdy;

  modport slave (
    input  b0rom_cs, b0rom_addr, b1rom_cs, b1rom_addr,
           b2rom_cs, b2rom_addr, orom_cs, orom_addr,
           mem_data, mem_rdy,
    output b0rom_data, b0rom_ok, b1rom_data, b1rom_ok,
           b2rom_data, b2rom_ok, orom_data, orom_ok,
           mem_rd, mem_addr
  );

  modport master (
    output b0rom_cs, b0rom_addr, b1rom_cs, b1rom_addr,
           b2rom_cs, b2rom_addr, orom_cs, orom_addr,
           mem_data, mem_rdy,
    input  b0rom_data, b0rom_ok, b1rom_data, b1rom_ok,
           b2rom_data, b2rom_ok, orom_data, orom_ok,
           mem_rd, mem_addr
  );
endinterface

// File: rtl/jtcop_gfxarb_slot.sv
// Single-word cache for one ROM client: combinational hit/ok, miss request.
// Filled by the arbiter with the address that was actually read, not the live one.
module jtcop_gfxarb_slot
  import jtcop_gfxarb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cs,
  input  logic [CAW-1:0] i_addr,
  input  logic           i_busy,
  input  logic           i_fill,
  input  logic [CAW-1:0] i_fill_addr,
  input  logic [DW-1:0]  i_fill_data,
  output logic [DW-1:0]  o_data,
  output logic           o_ok,
  output logic           o_pend
);

  logic [CAW-1:0] r_caddr;
  logic [DW-1:0]  r_cdata;
  logic           r_valid;
  logic           w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_caddr <= '0;
      r_cdata <= '0;
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_caddr <= i_fill_addr;
      r_cdata <= i_fill_data;
      r_valid <= 1'b1;
    end
  end

  assign w_hit  = i_cs & r_valid & (i_addr == r_caddr);
  assign o_ok   = w_hit;
  assign o_pend = i_cs & ~w_hit & ~i_busy;
  assign o_data = r_cdata;

endmodule

// File: rtl/jtcop_gfxarb.sv
// Graphics ROM arbiter: four cached clients share one 32-bit read port, one read at a time.
// JTCOP_GFXARB_RR_EN selects round-robin grant; otherwise fixed priority obj > BA2 > BA0 > BA1.
module jtcop_gfxarb
  import jtcop_gfxarb_pkg::*;
#(
  parameter int                MEM_AW = 22,
  parameter logic [MEM_AW-1:0] BASE0  = MEM_AW'(22'h00000),
  parameter logic [MEM_AW-1:0] BASE1  = MEM_AW'(22'h40000),
  parameter logic [MEM_AW-1:0] BASE2  = MEM_AW'(22'h80000),
  parameter logic [MEM_AW-1:0] BASE3  = MEM_AW'(22'hC0000)
)(
  input  logic           clk,
  input  logic           rst,
  jtcop_gfxarb_if.slave  gfx
);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_gnt, w_gnt;
  logic [CAW-1:0]    r_gaddr;
  logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              w_grant;

  logic [NCL-1:0]    w_cs, w_pend, w_ok, w_fill, w_busy;
  logic [CAW-1:0]    w_addr [NCL];
  logic [DW-1:0]     w_data [NCL];

  assign w_cs = {gfx.orom_cs, gfx.b2rom_cs, gfx.b1rom_cs, gfx.b0rom_cs};
  assign w_addr[CL_BA0] = gfx.b0rom_addr;
  assign w_addr[CL_BA1] = gfx.b1rom_addr;
  assign w_addr[CL_BA2] = gfx.b2rom_addr;
  assign w_addr[CL_OBJ] = gfx.orom_addr;

  for (genvar gi = 0; gi < NCL; gi++) begin : g_slot
    assign w_busy[gi] = (r_state != IDLE) && (r_gnt == 2'(gi));
    jtcop_gfxarb_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_cs        (w_cs[gi]),
      .i_addr      (w_addr[gi]),
      .i_busy      (w_busy[gi]),
      .i_fill      (w_fill[gi]),
      .i_fill_addr (r_gaddr),
      .i_fill_data (gfx.mem_data),
      .o_data      (w_data[gi]),
      .o_ok        (w_ok[gi]),
      .o_pend      (w_pend[gi])
    );
  end

  assign gfx.b0rom_data = w_data[CL_BA0];
  assign gfx.b1rom_data = w_data[CL_BA1];
  assign gfx.b2rom_data = w_data[CL_BA2];
  assign gfx.orom_data  = w_data[CL_OBJ];
  assign gfx.b0rom_ok   = w_ok[CL_BA0];
  assign gfx.b1rom_ok   = w_ok[CL_BA1];
  assign gfx.b2rom_ok   = w_ok[CL_BA2];
  assign gfx.orom_ok    = w_ok[CL_OBJ];

  assign w_grant = (r_state == IDLE) && (|w_pend);

`ifdef JTCOP_GFXARB_RR_EN
  logic [1:0] r_ptr, w_idx;
  logic       w_found;

  always_comb begin
    w_gnt   = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NCL; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_pend[w_idx]) begin
        w_gnt   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= '0;
    else if (w_grant) r_ptr <= w_gnt;
  end
`else
  assign w_gnt = fixed_pick(w_pend);
`endif

  function automatic logic [MEM_AW-1:0] base_of(input logic [1:0] idx);
    case (idx)
      CL_BA0:  return BASE0;
      CL_BA1:  return BASE1;
      CL_BA2:  return BASE2;
      default: return BASE3;
    endcase
  endfunction

  // Region offset added in MEM_AW bits; overflow wraps silently.
  assign w_mem_addr_nxt = base_of(w_gnt) + MEM_AW'(w_addr[w_gnt]);

  always_comb begin
    w_state_nxt = r_state;
    w_fill      = '0;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = WAIT;
      WAIT: if (gfx.mem_rdy) begin
        w_fill[r_gnt] = 1'b1;
        w_state_nxt   = FILL;
      end
      FILL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gaddr    <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt      <= w_gnt;
        r_gaddr    <= w_addr[w_gnt];
        r_mem_addr <= w_mem_addr_nxt;
      end
    end
  end

  assign gfx.mem_rd   = (r_state == WAIT);
  assign gfx.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_jtcop_gfxarb.sv
// Directed bench for jtcop_gfxarb: cycle table for single-client traffic, hand sequences for contention and reset.
module tb_jtcop_gfxarb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jtcop_gfxarb_if #(.MEM_AW(22)) gfx();

  jtcop_gfxarb dut (
    .clk (clk),
    .rst (rst),
    .gfx (gfx.slave)
  );

  typedef struct {
    string       name;
    logic [3:0]  cs;
    logic [17:0] a0;
    logic [17:0] a1;
    logic        rdy;
    logic [31:0] md;
    logic        exp_rd;
    logic [21:0] exp_ma;
    logic [3:0]  exp_ok;
    int          dsel;
    logic [31:0] exp_d;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  function automatic vec_t mkv(string nm, logic [3:0] cs, logic [17:0] a0, logic [17:0] a1,
                               logic rdy, logic [31:0] md, logic erd, logic [21:0] ema,
                               logic [3:0] eok, int dsel, logic [31:0] ed);
    vec_t r;
    r.name = nm; r.cs = cs; r.a0 = a0; r.a1 = a1; r.rdy = rdy; r.md = md;
    r.exp_rd = erd; r.exp_ma = ema; r.exp_ok = eok; r.dsel = dsel; r.exp_d = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] okv();
    return {gfx.orom_ok, gfx.b2rom_ok, gfx.b1rom_ok, gfx.b0rom_ok};
  endfunction

  function automatic logic [31:0] dat(input int i);
    case (i)
      0:       return gfx.b0rom_data;
      1:       return gfx.b1rom_data;
      2:       return gfx.b2rom_data;
      default: return gfx.orom_data;
    endcase
  endfunction

  task automatic clr_inputs();
    gfx.b0rom_cs = 0; gfx.b0rom_addr = '0;
    gfx.b1rom_cs = 0; gfx.b1rom_addr = '0;
    gfx.b2rom_cs = 0; gfx.b2rom_addr = '0;
    gfx.orom_cs  = 0; gfx.orom_addr  = '0;
    gfx.mem_rdy  = 0; gfx.mem_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_rd(input string nm);
    int c = 0;
    @(negedge clk);
    while (gfx.mem_rd !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(gfx.mem_rd), 64'd1);
  endtask

  logic [21:0] exp_ord [4];
  logic [21:0] base_t  [4];

  initial begin
    clr_inputs();

    v[0]  = mkv("reset",    4'b0000, 18'h123, 18'h00, 0, 32'h0,        0, 22'h00000, 4'b0000, 0, 32'h0);
    v[1]  = mkv("t1_miss",  4'b0001, 18'h123, 18'h00, 0, 32'h0,        0, 22'h00000, 4'b0000, 4, 32'h0);
    v[2]  = mkv("t1_rd",    4'b0001, 18'h123, 18'h00, 0, 32'h0,        1, 22'h00123, 4'b0000, 4, 32'h0);
    v[3]  = mkv("t1_wait1", 4'b0001, 18'h123, 18'h00, 0, 32'h0,        1, 22'h00123, 4'b0000, 4, 32'h0);
    v[4]  = mkv("t1_wait2", 4'b0001, 18'h123, 18'h00, 0, 32'h0,        1, 22'h00123, 4'b0000, 4, 32'h0);
    v[5]  = mkv("t1_wait3", 4'b0001, 18'h123, 18'h00, 0, 32'h0,        1, 22'h00123, 4'b0000, 4, 32'h0);
    v[6]  = mkv("t1_rdy",   4'b0001, 18'h123, 18'h00, 1, 32'hDEADBEEF, 1, 22'h00123, 4'b0000, 4, 32'h0);
    v[7]  = mkv("t1_ok",    4'b0001, 18'h123, 18'h00, 0, 32'h0,        0, 22'h00123, 4'b0001, 0, 32'hDEADBEEF);
    v[8]  = mkv("t1_hold",  4'b0001, 18'h123, 18'h00, 0, 32'h0,        0, 22'h00123, 4'b0001, 0, 32'hDEADBEEF);
    v[9]  = mkv("t6_spur",  4'b0001, 18'h123, 18'h00, 1, 32'h11111111, 0, 22'h00123, 4'b0001, 0, 32'hDEADBEEF);
    v[10] = mkv("t6_after", 4'b0001, 18'h123, 18'h00, 0, 32'h0,        0, 22'h00123, 4'b0001, 0, 32'hDEADBEEF);
    v[11] = mkv("t3_miss",  4'b0011, 18'h123, 18'h10, 0, 32'h0,        0, 22'h00123, 4'b0001, 4, 32'h0);
    v[12] = mkv("t3_rd",    4'b0011, 18'h123, 18'h10, 1, 32'hA5A50010, 1, 22'h40010, 4'b0001, 4, 32'h0);
    v[13] = mkv("t3_fill",  4'b0011, 18'h123, 18'h10, 0, 32'h0,        0, 22'h40010, 4'b0011, 1, 32'hA5A50010);
    v[14] = mkv("t3_hit",   4'b0011, 18'h123, 18'h10, 0, 32'h0,        0, 22'h40010, 4'b0011, 1, 32'hA5A50010);
    v[15] = mkv("t3_chg",   4'b0011, 18'h123, 18'h11, 0, 32'h0,        0, 22'h40010, 4'b0001, 1, 32'hA5A50010);
    v[16] = mkv("t3_rd2",   4'b0011, 18'h123, 18'h11, 0, 32'h0,        1, 22'h40011, 4'b0001, 4, 32'h0);
    v[17] = mkv("t3_rdy2",  4'b0011, 18'h123, 18'h11, 1, 32'h00000011, 1, 22'h40011, 4'b0001, 4, 32'h0);
    v[18] = mkv("t3_ok2",   4'b0011, 18'h123, 18'h11, 0, 32'h0,        0, 22'h40011, 4'b0011, 1, 32'h00000011);
    v[19] = mkv("t3_drop",  4'b0000, 18'h123, 18'h11, 0, 32'h0,        0, 22'h40011, 4'b0000, 4, 32'h0);

    base_t[0] = 22'h00000; base_t[1] = 22'h40000;
    base_t[2] = 22'h80000; base_t[3] = 22'hC0000;
`ifdef JTCOP_GFXARB_RR_EN
    exp_ord[0] = 22'h40101; exp_ord[1] = 22'h80102;
    exp_ord[2] = 22'hC0103; exp_ord[3] = 22'h00100;
`else
    exp_ord[0] = 22'hC0103; exp_ord[1] = 22'h80102;
    exp_ord[2] = 22'h00100; exp_ord[3] = 22'h40101;
`endif

    // Tests 1, 3, 6: one vector per cycle, driven after the edge and checked at the falling edge.
    do_reset();
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      gfx.b0rom_cs = v[k].cs[0]; gfx.b0rom_addr = v[k].a0;
      gfx.b1rom_cs = v[k].cs[1]; gfx.b1rom_addr = v[k].a1;
      gfx.b2rom_cs = v[k].cs[2]; gfx.orom_cs    = v[k].cs[3];
      gfx.mem_rdy  = v[k].rdy;   gfx.mem_data   = v[k].md;
      @(negedge clk);
      chk({v[k].name, "_rd"}, 64'(gfx.mem_rd),   64'(v[k].exp_rd));
      chk({v[k].name, "_ma"}, 64'(gfx.mem_addr), 64'(v[k].exp_ma));
      chk({v[k].name, "_ok"}, 64'(okv()),        64'(v[k].exp_ok));
      if (v[k].dsel < 4)
        chk({v[k].name, "_data"}, 64'(dat(v[k].dsel)), 64'(v[k].exp_d));
    end

    // Test 2: simultaneous requests, mem_rdy two cycles after mem_rd.
    do_reset();
    gfx.b0rom_cs = 1; gfx.b0rom_addr = 18'h100;
    gfx.b1rom_cs = 1; gfx.b1rom_addr = 18'h101;
    gfx.b2rom_cs = 1; gfx.b2rom_addr = 18'h102;
    gfx.orom_cs  = 1; gfx.orom_addr  = 18'h103;
    for (int n = 0; n < 4; n++) begin
      wait_rd($sformatf("t2_rd%0d", n));
      chk($sformatf("t2_order%0d", n), 64'(gfx.mem_addr), 64'(exp_ord[n]));
      @(posedge clk); #1;
      @(posedge clk); #1;
      gfx.mem_rdy = 1; gfx.mem_data = 32'hF0000000 | 32'(gfx.mem_addr);
      @(posedge clk); #1;
      gfx.mem_rdy = 0;
    end
    @(negedge clk);
    chk("t2_all_ok", 64'(okv()), 64'hF);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_data%0d", i), 64'(dat(i)),
          64'(32'hF0000000 | 32'(base_t[i] + 22'h100 + 22'(i))));

    // Test 4: BA2 address changes while its read is outstanding.
    do_reset();
    gfx.b2rom_cs = 1; gfx.b2rom_addr = 18'h200;
    wait_rd("t4_rd1");
    chk("t4_ma1", 64'(gfx.mem_addr), 64'h80200);
    @(posedge clk); #1;
    gfx.b2rom_addr = 18'h201; gfx.mem_rdy = 1; gfx.mem_data = 32'hBBBB0200;
    @(negedge clk);
    chk("t4_ok_wait", 64'(gfx.b2rom_ok), 64'd0);
    @(posedge clk); #1;
    gfx.mem_rdy = 0;
    @(negedge clk);
    chk("t4_fill_rd", 64'(gfx.mem_rd), 64'd0);
    chk("t4_fill_ok", 64'(gfx.b2rom_ok), 64'd0);
    chk("t4_old_word", 64'(gfx.b2rom_data), 64'hBBBB0200);
    wait_rd("t4_rd2");
    chk("t4_ma2", 64'(gfx.mem_addr), 64'h80201);
    chk("t4_ok_pre", 64'(gfx.b2rom_ok), 64'd0);
    @(posedge clk); #1;
    gfx.mem_rdy = 1; gfx.mem_data = 32'hBBBB0201;
    @(negedge clk);
    chk("t4_ok_rdy", 64'(gfx.b2rom_ok), 64'd0);
    @(posedge clk); #1;
    gfx.mem_rdy = 0;
    @(negedge clk);
    chk("t4_ok_new", 64'(gfx.b2rom_ok), 64'd1);
    chk("t4_new_word", 64'(gfx.b2rom_data), 64'hBBBB0201);

    // Test 5: reset mid-WAIT clears everything; a previously cached address misses again.
    do_reset();
    gfx.orom_cs = 1; gfx.orom_addr = 18'h300;
    wait_rd("t5_rd1");
    chk("t5_ma1", 64'(gfx.mem_addr), 64'hC0300);
    @(posedge clk); #1;
    gfx.mem_rdy = 1; gfx.mem_data = 32'h33330300;
    @(posedge clk); #1;
    gfx.mem_rdy = 0;
    @(negedge clk);
    chk("t5_hit", 64'(gfx.orom_ok), 64'd1);
    @(posedge clk); #1;
    gfx.b0rom_cs = 1; gfx.b0rom_addr = 18'h050;
    wait_rd("t5_rd2");
    chk("t5_ma2", 64'(gfx.mem_addr), 64'h00050);
    @(posedge clk); #1;
    rst = 1; gfx.b0rom_cs = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_rst_rd", 64'(gfx.mem_rd), 64'd0);
    chk("t5_rst_ok", 64'(okv()), 64'd0);
    chk("t5_rst_ma", 64'(gfx.mem_addr), 64'd0);
    chk("t5_rst_data", 64'(gfx.orom_data), 64'd0);
    wait_rd("t5_rereq");
    chk("t5_rereq_ma", 64'(gfx.mem_addr), 64'hC0300);
    chk("t5_rereq_ok", 64'(gfx.orom_ok), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
